// File: rtl/rfetch_sb_stage_pkg.sv
// rfetch_sb_stage_pkg: shared types for the register-fetch stage.
// Holds the decoded control word layout, the raw-immediate geometry and
// the immediate builder used by the stage.
package rfetch_sb_stage_pkg;

   localparam int RVGA_IMM_LSB = 7;
   localparam int RVGA_IMM_W   = 32 - RVGA_IMM_LSB;
   localparam int RVGA_REG_W   = 5;
   localparam int RVGA_XLEN    = 32;
   localparam int RVGA_PEND_W  = 2;

   typedef logic [RVGA_XLEN-1:0]   rvga_word;
   typedef logic [RVGA_PEND_W-1:0] rvga_pend_t;

   typedef enum logic [2:0] {
      INST_R = 3'd0,
      INST_I = 3'd1,
      INST_S = 3'd2,
      INST_B = 3'd3,
      INST_U = 3'd4,
      INST_J = 3'd5
   } rvga_inst_e;

   typedef struct packed {
      logic [RVGA_REG_W-1:0] rs1;
      logic [RVGA_REG_W-1:0] rs2;
      logic [RVGA_REG_W-1:0] rd;
      logic                  rd_w_v;
      rvga_inst_e            inst_type;
      logic                  shift_v;
      logic                  br_v;
   } rvga_cword;

   // Builds the 32-bit immediate from instruction bits [31:7]; raw bit k is
   // instruction bit k+7. Shift-immediates yield the zero-extended shamt.
   function automatic rvga_word imm_construct(input rvga_inst_e             inst_type,
                                              input logic                   shift_v,
                                              input logic [RVGA_IMM_W-1:0] r);
      rvga_word imm;
      imm = '0;
      case (inst_type)
         INST_I:  imm = shift_v ? {27'd0, r[17:13]} : {{20{r[24]}}, r[24:13]};
         INST_S:  imm = {{20{r[24]}}, r[24:18], r[4:0]};
         INST_B:  imm = {{19{r[24]}}, r[24], r[0], r[23:18], r[4:1], 1'b0};
         INST_U:  imm = {r[24:5], 12'd0};
         INST_J:  imm = {{11{r[24]}}, r[24], r[12:5], r[13], r[23:14], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/rfetch_sb_stage_scoreboard.sv
// rfetch_sb_stage_scoreboard: per-register pending-write counters.
// Counts issued-but-not-written-back writes per register and answers the
// hazard query for the staged op. r0 is never tracked.
module rfetch_sb_stage_scoreboard
   import rfetch_sb_stage_pkg::*;
#(
   parameter int  regs_p     = 32,
   parameter int  wb_ports_p = 1,
   parameter int  pend_w_p   = 2,
   localparam int reg_w_lp   = $clog2(regs_p)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                inc_v_i,
   input  logic [reg_w_lp-1:0]                 inc_rd_i,
   input  logic [wb_ports_p-1:0]               dec_v_i,
   input  logic [wb_ports_p-1:0][reg_w_lp-1:0] dec_rd_i,
   input  logic [reg_w_lp-1:0]                 rs1_i,
   input  logic [reg_w_lp-1:0]                 rs2_i,
   input  logic [reg_w_lp-1:0]                 rd_i,
   input  logic                                rd_w_v_i,
   input  logic                                rs1_rel_i,
   input  logic                                rs2_rel_i,
   output logic                                hazard_o
);

   localparam int                  cnt_w_lp    = pend_w_p + 3;
   localparam logic [pend_w_p-1:0] pend_max_lp = '1;

   logic [pend_w_p-1:0] pend     [regs_p];
   logic [pend_w_p-1:0] pend_nxt [regs_p];
   logic [cnt_w_lp-1:0] dec_cnt  [regs_p];
   logic [regs_p-1:0]   inc_hit;
   logic [regs_p-1:0]   underflow;
   logic                rs1_haz, rs2_haz, rd_haz;

   // Next counter value: +1 on issue, -k for k writeback ports naming the reg.
   always_comb begin
      for (int r = 0; r < regs_p; r++) begin
         // NOTE: every output of this block is assigned before any condition,
         // so no path leaves a value unassigned and no latch is inferred.
         dec_cnt[r]   = '0;
         inc_hit[r]   = 1'b0;
         underflow[r] = 1'b0;
         pend_nxt[r]  = pend[r];
         if (r != 0) begin
            for (int p = 0; p < wb_ports_p; p++) begin
               if (dec_v_i[p] && dec_rd_i[p] == reg_w_lp'(r))
                  dec_cnt[r] = dec_cnt[r] + cnt_w_lp'(1);
            end
            inc_hit[r]   = inc_v_i && inc_rd_i == reg_w_lp'(r);
            underflow[r] = dec_cnt[r] > cnt_w_lp'(pend[r]) + cnt_w_lp'(inc_hit[r]);
            pend_nxt[r]  = pend_w_p'(cnt_w_lp'(pend[r]) + cnt_w_lp'(inc_hit[r]) - dec_cnt[r]);
         end
      end
   end

   // Counter state; cleared on reset, otherwise follows pend_nxt.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the counters are a small memory that must start at zero, so
         // each entry is reset explicitly; state uses non-blocking updates so
         // every counter samples the same pre-edge values.
         for (int r = 0; r < regs_p; r++) pend[r] <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   // A writeback to a register with no outstanding write is a protocol error.
   assert property (@(posedge clk_i) disable iff (rst_i) underflow == '0);

   // Hazard query; a source released this cycle with one pending write is
   // cleared when its data is being forwarded.
   assign rs1_haz  = rs1_i != '0 && pend[rs1_i] != '0 &&
                     !(rs1_rel_i && pend[rs1_i] == pend_w_p'(1));
   assign rs2_haz  = rs2_i != '0 && pend[rs2_i] != '0 &&
                     !(rs2_rel_i && pend[rs2_i] == pend_w_p'(1));
   assign rd_haz   = rd_w_v_i && rd_i != '0 && pend[rd_i] == pend_max_lp;
   assign hazard_o = rs1_haz | rs2_haz | rd_haz;

endmodule

// File: rtl/rfetch_sb_stage.sv
// rfetch_sb_stage: register-fetch stage between decode and execute.
// Stages one decoded op, reads its operands from the regfile, builds the
// immediate and holds the op while the scoreboard reports a hazard.
// Macro RVGA_RF_BYPASS_EN: forward same-cycle writeback data to the staged
// operands so a waiting op issues in the writeback cycle.
module rfetch_sb_stage
   import rfetch_sb_stage_pkg::*;
#(
   parameter int  xlen_p     = 32,
   parameter int  regs_p     = 32,
   parameter int  wb_ports_p = 1,
   parameter int  pend_w_p   = 2,
   localparam int reg_w_lp   = $clog2(regs_p)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic                                in_v_i,
   output logic                                in_ready_o,
   input  rvga_cword                           cword_i,
   input  logic [RVGA_IMM_W-1:0]               imm_raw_i,
   output logic                                out_v_o,
   input  logic                                out_ready_i,
   output rvga_cword                           cword_o,
   output logic [xlen_p-1:0]                   imm_data_o,
   output logic [xlen_p-1:0]                   rs1_data_o,
   output logic [xlen_p-1:0]                   rs2_data_o,
   output logic                                br_v_o,
   input  logic [wb_ports_p-1:0]               wb_v_i,
   input  logic [wb_ports_p-1:0]               wb_kill_i,
   input  logic [wb_ports_p-1:0][reg_w_lp-1:0] wb_rd_i,
   input  logic [wb_ports_p-1:0][xlen_p-1:0]   wb_data_i
);

   logic                  stg_v;
   rvga_cword             stg_cword;
   logic [RVGA_IMM_W-1:0] stg_imm_raw;
   logic [xlen_p-1:0]     rf [regs_p];
   logic                  hazard, fire, accept, inc_v;
   logic [reg_w_lp-1:0]   rs1_idx, rs2_idx, rd_idx;
   logic                  rs1_byp_v, rs2_byp_v;
   logic [xlen_p-1:0]     rs1_byp_data, rs2_byp_data;

   assign rs1_idx    = stg_cword.rs1[reg_w_lp-1:0];
   assign rs2_idx    = stg_cword.rs2[reg_w_lp-1:0];
   assign rd_idx     = stg_cword.rd[reg_w_lp-1:0];
   assign out_v_o    = stg_v & ~hazard;
   assign fire       = out_v_o & out_ready_i;
   assign in_ready_o = ~stg_v | fire;
   assign accept     = in_v_i & in_ready_o;
   assign inc_v      = fire & stg_cword.rd_w_v & (rd_idx != '0);
   assign cword_o    = stg_cword;
   assign br_v_o     = stg_cword.br_v & out_v_o;
   assign imm_data_o = xlen_p'(signed'(imm_construct(stg_cword.inst_type,
                                                     stg_cword.shift_v, stg_imm_raw)));

   // Stage register; flush beats accept, and an op leaves when it fires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_v       <= 1'b0;
         stg_cword   <= '0;
         stg_imm_raw <= '0;
      end else if (flush_i) begin
         stg_v <= 1'b0;
      end else if (accept) begin
         stg_v       <= 1'b1;
         stg_cword   <= cword_i;
         stg_imm_raw <= imm_raw_i;
      end else if (fire) begin
         stg_v <= 1'b0;
      end
   end

   // Regfile write; ascending port order makes the highest port win on a
   // shared rd. Killed writebacks and r0 never update the array.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < regs_p; r++) rf[r] <= '0;
      end else begin
         for (int p = 0; p < wb_ports_p; p++) begin
            if (wb_v_i[p] && !wb_kill_i[p] && wb_rd_i[p] != '0)
               rf[wb_rd_i[p]] <= wb_data_i[p];
         end
      end
   end

   // Operand select; forwarded writeback data overrides the regfile.
   always_comb begin
      rs1_byp_v    = 1'b0;
      rs2_byp_v    = 1'b0;
      rs1_byp_data = '0;
      rs2_byp_data = '0;
`ifdef RVGA_RF_BYPASS_EN
      for (int p = 0; p < wb_ports_p; p++) begin
         if (wb_v_i[p] && !wb_kill_i[p] && wb_rd_i[p] != '0) begin
            if (wb_rd_i[p] == rs1_idx) begin
               rs1_byp_v    = 1'b1;
               rs1_byp_data = wb_data_i[p];
            end
            if (wb_rd_i[p] == rs2_idx) begin
               rs2_byp_v    = 1'b1;
               rs2_byp_data = wb_data_i[p];
            end
         end
      end
`endif
      rs1_data_o = rs1_byp_v ? rs1_byp_data : rf[rs1_idx];
      rs2_data_o = rs2_byp_v ? rs2_byp_data : rf[rs2_idx];
   end

   rfetch_sb_stage_scoreboard #(
      .regs_p     (regs_p),
      .wb_ports_p (wb_ports_p),
      .pend_w_p   (pend_w_p)
   ) u_scoreboard (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_v_i   (inc_v),
      .inc_rd_i  (rd_idx),
      .dec_v_i   (wb_v_i),
      .dec_rd_i  (wb_rd_i),
      .rs1_i     (rs1_idx),
      .rs2_i     (rs2_idx),
      .rd_i      (rd_idx),
      .rd_w_v_i  (stg_cword.rd_w_v),
      .rs1_rel_i (rs1_byp_v),
      .rs2_rel_i (rs2_byp_v),
      .hazard_o  (hazard)
   );

endmodule

// File: tb/tb_rfetch_sb_stage.sv
// tb_rfetch_sb_stage: directed bench for rfetch_sb_stage with two writeback
// ports. An immediate table is swept first, then hand-written sequences
// cover RAW holds, counter saturation, multi-port writeback, flush/kill
// and a long output stall.
module tb_rfetch_sb_stage;
   import rfetch_sb_stage_pkg::*;

   logic             clk = 1'b0;
   logic             rst, flush, in_v, in_ready, out_v, out_ready, br_v;
   rvga_cword        cword_in, cword_out;
   logic [24:0]      imm_raw;
   logic [31:0]      imm_data, rs1_data, rs2_data;
   logic [1:0]       wb_v, wb_kill;
   logic [1:0][4:0]  wb_rd;
   logic [1:0][31:0] wb_data;
   int               checks = 0;
   int               errors = 0;

   typedef struct {
      rvga_inst_e  t;
      logic        sh;
      logic        br;
      logic [24:0] raw;
      logic [31:0] exp_imm;
   } imm_vec_t;

   imm_vec_t vecs[8];

   always #5 clk = ~clk;

   rfetch_sb_stage #(
      .xlen_p(32), .regs_p(32), .wb_ports_p(2), .pend_w_p(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_v_i(in_v), .in_ready_o(in_ready),
      .cword_i(cword_in), .imm_raw_i(imm_raw), .out_v_o(out_v), .out_ready_i(out_ready),
      .cword_o(cword_out), .imm_data_o(imm_data), .rs1_data_o(rs1_data),
      .rs2_data_o(rs2_data), .br_v_o(br_v), .wb_v_i(wb_v), .wb_kill_i(wb_kill),
      .wb_rd_i(wb_rd), .wb_data_i(wb_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic rvga_cword mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic rd_w_v,
                                    input rvga_inst_e t, input logic sh, input logic br);
      rvga_cword c;
      c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.rd_w_v = rd_w_v;
      c.inst_type = t; c.shift_v = sh; c.br_v = br;
      return c;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one op for one edge, then withdraw it and let outputs settle.
   task automatic issue(input rvga_cword cw, input logic [24:0] raw);
      cword_in = cw;
      imm_raw  = raw;
      in_v     = 1'b1;
      cycle();
      in_v = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{INST_I, 1'b0, 1'b0, 25'h000A000, 32'h0000_0005};
      vecs[1] = '{INST_I, 1'b0, 1'b0, 25'h1FFE000, 32'hFFFF_FFFF};
      vecs[2] = '{INST_S, 1'b0, 1'b0, 25'h1FC0018, 32'hFFFF_FFF8};
      vecs[3] = '{INST_B, 1'b0, 1'b1, 25'h0000010, 32'h0000_0010};
      vecs[4] = '{INST_B, 1'b0, 1'b1, 25'h1FC001F, 32'hFFFF_FFFE};
      vecs[5] = '{INST_U, 1'b0, 1'b0, 25'h02468A0, 32'h1234_5000};
      vecs[6] = '{INST_J, 1'b0, 1'b0, 25'h0002000, 32'h0000_0800};
      vecs[7] = '{INST_I, 1'b1, 1'b0, 25'h083E000, 32'h0000_001F};

      rst = 1'b1; flush = 1'b1; in_v = 1'b0; out_ready = 1'b1;
      wb_v = '0; wb_kill = '0; wb_rd = '0; wb_data = '0;
      cword_in = '0; imm_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0;
      #1;
      check("rst_out_v", 32'(out_v), 32'd0);
      check("rst_br_v", 32'(br_v), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Immediate table: x0 sources, no dest write, fires one cycle later.
      for (int i = 0; i < 8; i++) begin
         issue(mk(5'd0, 5'd0, 5'd0, 1'b0, vecs[i].t, vecs[i].sh, vecs[i].br), vecs[i].raw);
         check("vec_out_v", 32'(out_v), 32'd1);
         check("vec_imm", imm_data, vecs[i].exp_imm);
         check("vec_br_v", 32'(br_v), 32'(vecs[i].br));
         check("vec_cword", 32'(cword_out),
               32'(mk(5'd0, 5'd0, 5'd0, 1'b0, vecs[i].t, vecs[i].sh, vecs[i].br)));
         cycle();
      end

      // ADDI x1, imm 5: leaves one pending write on x1.
      issue(mk(5'd0, 5'd0, 5'd1, 1'b1, INST_I, 1'b0, 1'b0), 25'h000A000);
      check("addi_out_v", 32'(out_v), 32'd1);
      check("addi_imm", imm_data, 32'd5);
      cycle();

      // Write x3 then read x3: the reader is held until x3 is written back.
      issue(mk(5'd0, 5'd0, 5'd3, 1'b1, INST_R, 1'b0, 1'b0), 25'd0);
      check("wr_x3_out_v", 32'(out_v), 32'd1);
      issue(mk(5'd3, 5'd0, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("raw_hold_0", 32'(out_v), 32'd0);
      cycle();
      check("raw_hold_1", 32'(out_v), 32'd0);
      wb_v = 2'b01; wb_rd[0] = 5'd3; wb_data[0] = 32'h0000_DEAD;
      #1;
`ifdef RVGA_RF_BYPASS_EN
      check("raw_byp_out_v", 32'(out_v), 32'd1);
      check("raw_byp_rs1", rs1_data, 32'h0000_DEAD);
      cycle();
      wb_v = '0;
      #1;
      check("raw_byp_gone", 32'(out_v), 32'd0);
`else
      check("raw_wb_cycle", 32'(out_v), 32'd0);
      cycle();
      wb_v = '0;
      #1;
      check("raw_after_wb", 32'(out_v), 32'd1);
      check("raw_rs1", rs1_data, 32'h0000_DEAD);
      cycle();
`endif
      issue(mk(5'd0, 5'd3, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("x3_rs2", rs2_data, 32'h0000_DEAD);
      cycle();

      // Three writes to x5 saturate its counter; a fourth stalls.
      for (int i = 0; i < 3; i++) begin
         issue(mk(5'd0, 5'd0, 5'd5, 1'b1, INST_R, 1'b0, 1'b0), 25'd0);
         check("x5_issue", 32'(out_v), 32'd1);
         cycle();
      end
      issue(mk(5'd0, 5'd0, 5'd5, 1'b1, INST_R, 1'b0, 1'b0), 25'd0);
      check("x5_full_out_v", 32'(out_v), 32'd0);
      check("x5_full_in_ready", 32'(in_ready), 32'd0);
      wb_v = 2'b01; wb_rd[0] = 5'd5; wb_data[0] = 32'h50;
      #1;
      check("x5_full_wb_cycle", 32'(out_v), 32'd0);
      cycle();
      wb_v = '0;
      #1;
      check("x5_release", 32'(out_v), 32'd1);
      cycle();
      wb_v = 2'b11; wb_rd[0] = 5'd5; wb_rd[1] = 5'd5; wb_data[0] = 32'h51; wb_data[1] = 32'h52;
      cycle();
      wb_v = 2'b01; wb_data[0] = 32'h53;
      cycle();
      wb_v = '0;
      issue(mk(5'd5, 5'd5, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("x5_drained", 32'(out_v), 32'd1);
      check("x5_rs1", rs1_data, 32'h53);
      cycle();

      // Two pending writes to x7 released by both ports in one cycle.
      for (int i = 0; i < 2; i++) begin
         issue(mk(5'd0, 5'd0, 5'd7, 1'b1, INST_R, 1'b0, 1'b0), 25'd0);
         cycle();
      end
      wb_v = 2'b11; wb_rd[0] = 5'd7; wb_rd[1] = 5'd7; wb_data[0] = 32'h11; wb_data[1] = 32'h22;
      cycle();
      wb_v = '0;
      issue(mk(5'd7, 5'd7, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("x7_dual_dec", 32'(out_v), 32'd1);
      check("x7_rs1", rs1_data, 32'h22);
      check("x7_rs2", rs2_data, 32'h22);
      cycle();

      // A reader of x1 is held, then flushed while a new op is offered.
      issue(mk(5'd1, 5'd0, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("x1_pending", 32'(out_v), 32'd0);
      flush = 1'b1; in_v = 1'b1;
      cword_in = mk(5'd0, 5'd0, 5'd0, 1'b0, INST_U, 1'b0, 1'b0);
      imm_raw = 25'h02468A0;
      cycle();
      flush = 1'b0; in_v = 1'b0;
      #1;
      check("flush_out_v", 32'(out_v), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      cycle();
      check("flush_dropped", 32'(out_v), 32'd0);
      wb_v = 2'b01; wb_kill = 2'b01; wb_rd[0] = 5'd1; wb_data[0] = 32'h0BAD;
      cycle();
      wb_v = '0; wb_kill = '0;
      issue(mk(5'd1, 5'd0, 5'd0, 1'b0, INST_R, 1'b0, 1'b0), 25'd0);
      check("kill_release", 32'(out_v), 32'd1);
      check("kill_no_write", rs1_data, 32'd0);
      cycle();

      // Write attempt to x0, then a five-cycle output stall.
      wb_v = 2'b01; wb_rd[0] = 5'd0; wb_data[0] = 32'hFFFF;
      cycle();
      wb_v = '0;
      out_ready = 1'b0;
      issue(mk(5'd0, 5'd7, 5'd0, 1'b0, INST_I, 1'b0, 1'b0), 25'h000A000);
      cword_in = mk(5'd0, 5'd0, 5'd0, 1'b0, INST_I, 1'b0, 1'b0);
      imm_raw = 25'h1FFE000;
      in_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_out_v", 32'(out_v), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_x0", rs1_data, 32'd0);
         check("stall_rs2", rs2_data, 32'h22);
         check("stall_imm", imm_data, 32'd5);
         cycle();
      end
      out_ready = 1'b1;
      #1;
      check("stall_release", 32'(in_ready), 32'd1);
      cycle();
      in_v = 1'b0;
      #1;
      check("next_out_v", 32'(out_v), 32'd1);
      check("next_imm", imm_data, 32'hFFFF_FFFF);
      cycle();
      check("drained", 32'(out_v), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
